// File: rtl/digit_serial_addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// State and mode encodings live here so the top and the bench agree on them.
package digit_serial_addsub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Digit counter width; a single-digit operand still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Start/done request bundle between a datapath master and the
// digit-serial adder/subtractor.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             v;

    modport master (
        output start,
        output m,
        output a,
        output b,
        input  busy,
        input  done,
        input  s,
        input  cout,
        input  v
    );

    modport slave (
        input  start,
        input  m,
        input  a,
        input  b,
        output busy,
        output done,
        output s,
        output cout,
        output v
    );

endinterface

// File: rtl/digit_serial_addsub_digit_adder.sv
// DIGIT-bit ripple adder built from full_adder cells; exposes the
// carry into its top bit so the caller can form signed overflow.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = x ^ y ^ ci;
    assign co  = (x & y) | (ci & (x ^ y));

endmodule

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .x   (a[i]),
            .y   (b[i]),
            .ci  (c[i]),
            .sum (sum[i]),
            .co  (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle two's-complement add/sub, DIGIT bits per clock, LSB first.
// Optional clamp on overflow: define ADDSUB_SATURATE_EN.
module digit_serial_addsub
    import digit_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    digit_serial_addsub_if.slave  bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_w(N);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             a_msb;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             v_q;
    logic             done_q;

    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic             d_cmsb;

    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] s_fin;
    logic             last;
    logic             ovf;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .cin   (carry),
        .sum   (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

    // New digit enters at the top; after N shifts digit 0 sits at the LSB.
    always_comb begin
        sum_w            = '0;
        sum_w[DIGIT-1:0] = d_sum;
        res_nx = (res >> DIGIT) | (sum_w << (WIDTH - DIGIT));
    end

    assign last = (cnt == CNT_LAST);
    assign ovf  = d_cmsb ^ d_cout;

`ifdef ADDSUB_SATURATE_EN
    always_comb begin
        s_fin = res_nx;
        if (ovf) begin
            s_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign s_fin = res_nx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= (bus.m == MODE_SUB) ? ~bus.b : bus.b;
                        carry <= (bus.m == MODE_SUB);
                        a_msb <= bus.a[WIDTH-1];
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    res   <= res_nx;
                    carry <= d_cout;
                    cnt   <= cnt + CNT_ONE;
                    if (last) begin
                        s_q    <= s_fin;
                        cout_q <= d_cout;
                        v_q    <= ovf;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.v    = v_q;

endmodule
